// File: rtl/fifo_pkg.sv
// Shared types, defaults and Gray-code helpers for the asynchronous FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_DATASIZE = 32;
  localparam int unsigned FIFO_ADDRSIZE = 9;
  localparam int unsigned MAX_PTR_W     = 32;

  typedef logic [FIFO_ADDRSIZE:0] ptr_t;

  // Both helpers work at MAX_PTR_W; zero-extend narrower codes and truncate the result.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module fifo_gray_sync #(
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] q1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_rd_port.sv
// Read-side port of the async FIFO with a one-entry prefetch register on a valid/ready output.
// Optional almost-empty flag is built when FIFO_RD_AEMPTY_EN is defined.
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE      = FIFO_DATASIZE,
  parameter int unsigned ADDRSIZE      = FIFO_ADDRSIZE,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [DATASIZE-1:0] mem_rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  input  logic                rready
);

  if (ADDRSIZE + 1 > MAX_PTR_W) begin : g_bad_addrsize
    $error("fifo_rd_port: ADDRSIZE too large for Gray helpers");
  end
  if (AEMPTY_THRESH >= (1 << (ADDRSIZE + 1))) begin : g_bad_thresh
    $error("fifo_rd_port: AEMPTY_THRESH exceeds pointer range");
  end

  logic [ADDRSIZE:0] rq2_wptr;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic              rinc;

  fifo_gray_sync #(
    .Width(ADDRSIZE + 1)
  ) u_wptr_sync (
    .clk  (rclk),
    .rst_n(rrst_n),
    .d    (wptr),
    .q    (rq2_wptr)
  );

  // Pop from memory whenever there is a word and the prefetch slot is free or being emptied.
  always_comb begin
    rinc      = !rempty && (!rvalid || rready);
    rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rinc};
    rgraynext = (ADDRSIZE + 1)'(bin2gray(MAX_PTR_W'(rbinnext)));
  end

  assign raddr = rbin[ADDRSIZE-1:0];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      rempty <= (rgraynext == rq2_wptr);
      if (rinc) begin
        rdata  <= mem_rdata;
        rvalid <= 1'b1;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

`ifdef FIFO_RD_AEMPTY_EN
  logic [ADDRSIZE:0] wbin_s;
  logic [ADDRSIZE:0] rlevel;

  // Level counts words still in memory after this edge's pop; the prefetch word is excluded.
  always_comb begin
    wbin_s = (ADDRSIZE + 1)'(gray2bin(MAX_PTR_W'(rq2_wptr)));
    rlevel = wbin_s - rbinnext;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      raempty <= 1'b1;
    end else begin
      raempty <= (rlevel <= (ADDRSIZE + 1)'(AEMPTY_THRESH));
    end
  end
`else
  assign raempty = 1'b1;
`endif

endmodule

// File: doc/fifo_rd_port.md
# fifo_rd_port

Read-side port of the asynchronous FIFO, operating entirely in the read clock domain. It synchronizes the write Gray pointer, maintains the read binary/Gray pointer and the registered empty flag, and drives the read address into the dual-port FIFO memory. A one-entry prefetch register presents memory data to the consumer over a valid/ready handshake.

## Interface
- DATASIZE, 32, memory data word width
- ADDRSIZE, 9, memory address bits; pointers are ADDRSIZE+1 bits
- AEMPTY_THRESH, 4, almost-empty threshold in words (used only with FIFO_RD_AEMPTY_EN)
- rclk  in  1  read clock; the only clock
- rrst_n  in  1  asynchronous, active-low reset
- wptr  in  ADDRSIZE+1  write Gray pointer from the write domain, asynchronous to rclk
- mem_rdata  in  DATASIZE  combinational memory read data, equal to mem[raddr]
- raddr  out  ADDRSIZE  memory read address
- rptr  out  ADDRSIZE+1  registered read Gray pointer, sent to the write domain
- rempty  out  1  memory holds no unread word (prefetch register excluded)
- raempty  out  1  almost empty
- rdata  out  DATASIZE  output word
- rvalid  out  1  rdata holds a valid word
- rready  in  1  consumer accepts rdata

## Operation
- Synchronizer: two flops, rq1_wptr to rq2_wptr, both reset to 0; only rq2_wptr is used downstream.
- Pointers: rbin and rptr, reset 0. rinc = !rempty && (!rvalid || rready). rbinnext = rbin + rinc, modulo 2^(ADDRSIZE+1). rgraynext = (rbinnext>>1) ^ rbinnext. Both register on every rclk.
- raddr = rbin[ADDRSIZE-1:0], driven combinationally from the register.
- Empty: rempty <= (rgraynext == rq2_wptr); reset value 1.
- Prefetch: when rinc=1, rdata <= mem_rdata and rvalid <= 1. When rvalid && rready && !rinc, rvalid <= 0. Reset: rdata=0, rvalid=0.
- rdata and rvalid stay stable while rvalid && !rready. rready is ignored while rvalid=0.
- Simultaneous accept and refill (rvalid && rready && !rempty): the next word loads in the same edge and rvalid stays 1. Sustained throughput is 1 word/cycle.
- Wrap: the pointer MSB toggles each pass through the memory. raddr wraps from 2^ADDRSIZE-1 to 0. Empty is full-width Gray equality.
- Reset mid-operation: all state returns to reset values on the next rrst_n low, without waiting for rclk. A word held in the prefetch register is discarded.
- The block never reads while rempty=1. Underflow is therefore impossible.

## Timing
- wptr change to rempty=0: on the third rclk edge (two synchronizer edges plus the empty register).
- rempty=0 to rvalid=1: one edge, assuming the prefetch register is free.
- The rptr update is visible on the same edge that loads rdata.
- Accept to next rvalid: 0 cycles if the memory is non-empty, otherwise per the empty latency above.

## Configuration
- FIFO_RD_AEMPTY_EN defined:
  - wbin_s = gray2bin(rq2_wptr).
  - raempty <= ((wbin_s - rbinnext) mod 2^(ADDRSIZE+1)) <= AEMPTY_THRESH.
  - raempty resets to 1.
- FIFO_RD_AEMPTY_EN undefined: raempty is tied to 1'b1 and no Gray-to-binary logic is built.

## Structure
- Package fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterized by width;
  - default ADDRSIZE and DATASIZE constants;
  - the ptr_t typedef (ADDRSIZE+1 bits).
- Sub-module fifo_gray_sync (2-flop, parameterized width, async active-low reset) implements the wptr synchronizer. The write-side block reuses it for rptr.

## Test plan
- Reset: hold rrst_n=0 with wptr=10'h3FF -> rempty=1, rvalid=0, rptr=0, raddr=0, rdata=0, raempty=1.
- Single word: mem[0]=32'hA5A5_0001, wptr 0->1, rready=1 -> rempty=0 on edge 3; rvalid=1 and rdata=32'hA5A5_0001 on edge 4; rptr=1 and rempty=1 on edge 4.
- Backpressure: 4 words written, rready=0 -> exactly one prefetch, raddr=1, rdata stable for 20 cycles. Then raise rready -> words 0..3 delivered on 4 consecutive cycles, then rvalid=0.
- Wrap: preset pointers to rbin=510 and write 4 words -> raddr sequence 510, 511, 0, 1; rptr ends at Gray(514); data order preserved.
- Reset mid-stream: assert rrst_n low while rvalid=1 and rbin=7 -> outputs return to reset values immediately; after release, rempty=1 until the synchronized wptr differs from 0.
- Almost-empty (FIFO_RD_AEMPTY_EN, AEMPTY_THRESH=4): 6 words written, then drained -> raempty=0 while more than 4 words remain, raempty=1 once 4 or fewer remain.
